// File: rtl/cp0_pkg.sv
// Shared CP0 constants: register numbers, exception codes, field positions, handler vector.
// Optional timer support is selected with the CP0_TIMER_EN macro.
package cp0_pkg;

   localparam logic [31:0] PRID_VAL     = 32'h4652_4B00;
   localparam logic [31:0] HANDLER_ADDR = 32'h0000_4180;

   localparam logic [4:0] REG_COUNT   = 5'd9;
   localparam logic [4:0] REG_COMPARE = 5'd11;
   localparam logic [4:0] REG_SR      = 5'd12;
   localparam logic [4:0] REG_CAUSE   = 5'd13;
   localparam logic [4:0] REG_EPC     = 5'd14;
   localparam logic [4:0] REG_PRID    = 5'd15;

   localparam logic [4:0] EXC_INT     = 5'd0;
   localparam logic [4:0] EXC_ADEL    = 5'd4;
   localparam logic [4:0] EXC_ADES    = 5'd5;
   localparam logic [4:0] EXC_SYSCALL = 5'd8;
   localparam logic [4:0] EXC_RI      = 5'd10;
   localparam logic [4:0] EXC_OV      = 5'd12;

   localparam int SR_IE        = 0;
   localparam int SR_EXL       = 1;
   localparam int SR_IM_LO     = 10;
   localparam int SR_IM_HI     = 15;
   localparam int CAUSE_EXC_LO = 2;
   localparam int CAUSE_EXC_HI = 6;
   localparam int CAUSE_IP_LO  = 10;
   localparam int CAUSE_IP_HI  = 15;
   localparam int CAUSE_BD     = 31;

   // A delay-slot victim restarts at its branch, and EPC is always word aligned.
   function automatic logic [31:0] epc_capture(input logic [31:0] vpc, input logic bd);
      logic [31:0] pc;
      pc = bd ? (vpc - 32'd4) : vpc;
      return {pc[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer for CP0; only present when CP0_TIMER_EN is defined.
// TI latches on Count == Compare and is cleared by any accepted write to Compare.
`ifdef CP0_TIMER_EN
module cp0_timer
   import cp0_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        wr_en_i,
   input  logic [4:0]  addr_i,
   input  logic [31:0] data_i,
   output logic [31:0] count_o,
   output logic [31:0] compare_o,
   output logic        ti_o
);

   logic [31:0] count_q, count_d;
   logic [31:0] compare_q, compare_d;
   logic        ti_q, ti_d;

   always_comb begin
      count_d   = count_q + 32'd1;
      compare_d = compare_q;
      ti_d      = ti_q;
      if (count_q == compare_q) ti_d = 1'b1;
      if (wr_en_i && addr_i == REG_COUNT) count_d = data_i;
      if (wr_en_i && addr_i == REG_COMPARE) begin
         compare_d = data_i;
         ti_d      = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q   <= '0;
         compare_q <= '0;
         ti_q      <= 1'b0;
      end else begin
         count_q   <= count_d;
         compare_q <= compare_d;
         ti_q      <= ti_d;
      end
   end

   assign count_o   = count_q;
   assign compare_o = compare_q;
   assign ti_o      = ti_q;

endmodule
`endif

// File: rtl/cp0.sv
// MIPS coprocessor 0: SR/Cause/EPC/PRId, interrupt vs exception arbitration, eret target.
// Define CP0_TIMER_EN to add Count/Compare with the timer interrupt on IP[5].
module cp0
   import cp0_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        En,
   input  logic [4:0]  CP0Addr,
   input  logic [31:0] CP0In,
   output logic [31:0] CP0Out,
   input  logic [31:0] VPC,
   input  logic        BDIn,
   input  logic [4:0]  ExcCodeIn,
   input  logic [5:0]  HWInt,
   input  logic        EXLClr,
   output logic [31:0] EPCOut,
   output logic        Req
);

   logic [5:0]  im_q, im_d;
   logic        exl_q, exl_d;
   logic        ie_q, ie_d;
   logic        bd_q, bd_d;
   logic [5:0]  ip_q, ip_d;
   logic [4:0]  exc_code_q, exc_code_d;
   logic [31:0] epc_q, epc_d;

   logic [5:0]  ip_in;
   logic        int_req, exc_req, wr_en;
   logic [31:0] count_val, compare_val;

   assign wr_en = En & ~Req;

`ifdef CP0_TIMER_EN
   logic ti;

   cp0_timer u_timer (
      .clk       (clk),
      .reset     (reset),
      .wr_en_i   (wr_en),
      .addr_i    (CP0Addr),
      .data_i    (CP0In),
      .count_o   (count_val),
      .compare_o (compare_val),
      .ti_o      (ti)
   );

   assign ip_in = {HWInt[5] | ti, HWInt[4:0]};
`else
   assign count_val   = '0;
   assign compare_val = '0;
   assign ip_in       = HWInt;
`endif

   assign int_req = ie_q & ~exl_q & (|(ip_in & im_q));
   assign exc_req = ~exl_q & (ExcCodeIn != 5'd0);
   assign Req     = ~reset & (int_req | exc_req);

   always_comb begin
      im_d       = im_q;
      exl_d      = exl_q;
      ie_d       = ie_q;
      bd_d       = bd_q;
      ip_d       = ip_in;
      exc_code_d = exc_code_q;
      epc_d      = epc_q;
      if (Req) begin
         exl_d      = 1'b1;
         bd_d       = BDIn;
         exc_code_d = int_req ? EXC_INT : ExcCodeIn;
         epc_d      = epc_capture(VPC, BDIn);
      end else begin
         if (EXLClr) exl_d = 1'b0;
         if (wr_en) begin
            case (CP0Addr)
               REG_SR: begin
                  im_d  = CP0In[SR_IM_HI:SR_IM_LO];
                  exl_d = CP0In[SR_EXL];
                  ie_d  = CP0In[SR_IE];
               end
               REG_CAUSE: begin
                  bd_d       = CP0In[CAUSE_BD];
                  exc_code_d = CP0In[CAUSE_EXC_HI:CAUSE_EXC_LO];
               end
               REG_EPC: epc_d = CP0In;
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         im_q       <= '0;
         exl_q      <= 1'b0;
         ie_q       <= 1'b0;
         bd_q       <= 1'b0;
         ip_q       <= '0;
         exc_code_q <= '0;
         epc_q      <= '0;
      end else begin
         im_q       <= im_d;
         exl_q      <= exl_d;
         ie_q       <= ie_d;
         bd_q       <= bd_d;
         ip_q       <= ip_d;
         exc_code_q <= exc_code_d;
         epc_q      <= epc_d;
      end
   end

   always_comb begin
      CP0Out = '0;
      case (CP0Addr)
         REG_COUNT:   CP0Out = count_val;
         REG_COMPARE: CP0Out = compare_val;
         REG_SR: begin
            CP0Out[SR_IM_HI:SR_IM_LO] = im_q;
            CP0Out[SR_EXL]            = exl_q;
            CP0Out[SR_IE]             = ie_q;
         end
         REG_CAUSE: begin
            CP0Out[CAUSE_BD]                  = bd_q;
            CP0Out[CAUSE_IP_HI:CAUSE_IP_LO]   = ip_q;
            CP0Out[CAUSE_EXC_HI:CAUSE_EXC_LO] = exc_code_q;
         end
         REG_EPC:  CP0Out = epc_q;
         REG_PRID: CP0Out = PRID_VAL;
         default:  CP0Out = '0;
      endcase
   end

   // Forward an in-flight mtc0 EPC so a back-to-back eret sees the new target.
   assign EPCOut = (En && CP0Addr == REG_EPC) ? {CP0In[31:2], 2'b00} : epc_q;

endmodule
